// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, LSB first) feeding a byte FIFO with overflow/framing/break reporting.
// Define UART_RX_PARITY_EN to add an odd parity bit between the data bits and the stop bit.
module uart_rx_fifo #(
  parameter int BaudRate  = 4,
  parameter int FifoDepth = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] count,
  output logic       par_err,
  output logic       frm_err,
  output logic       ovf_err,
  output logic       brk_det
);

  localparam int CntW = $clog2(2 * BaudRate) + 1;
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [CntW-1:0] HalfEnd = CntW'(BaudRate - 1);
  localparam logic [CntW-1:0] FullEnd = CntW'(2 * BaudRate - 1);
  localparam logic [6:0]      DepthC  = 7'(FifoDepth);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

`ifdef UART_RX_PARITY_EN
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  logic            rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bad_q, par_bad_d;
  logic            par_bit_q, par_bit_d;
  logic            push_q, push_d;
  logic            par_err_q, par_err_d, frm_err_q, frm_err_d, ovf_err_q, ovf_err_d;
  logic            brk_det_q, brk_det_d;
  logic            frame_zero_s;

  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]      count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            pop_s, full_s, wr_en_s;

`ifdef UART_RX_PARITY_EN
  assign frame_zero_s = (shift_q == 8'h00) && !par_bit_q;
`else
  assign frame_zero_s = (shift_q == 8'h00);
`endif

  // Receive FSM next-state: mid-bit sampling driven by a per-bit cycle counter.
  always_comb begin
    rx_meta_d = RX;
    rx_sync_d = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    par_bit_d = par_bit_q;
    push_d    = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = 3'd0;
        par_bad_d = 1'b0;
        par_bit_d = 1'b0;
        if (!rx_sync_q) state_d = S_START;
        else            state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_q == HalfEnd) begin
          cnt_d = '0;
          if (rx_sync_q) state_d = S_IDLE;
          else           state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FullEnd) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FullEnd) begin
          cnt_d     = '0;
          par_bit_d = rx_sync_q;
          state_d   = S_STOP;
          if (!odd_parity_ok(shift_q, rx_sync_q)) begin
            par_bad_d = 1'b1;
            par_err_d = 1'b1;
          end else begin
            par_bad_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FullEnd) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            push_d  = !par_bad_q;
            state_d = S_IDLE;
          end else begin
            frm_err_d = 1'b1;
            if (frame_zero_s) state_d = S_BREAK;
            else              state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_BREAK: begin
        if (rx_sync_q) state_d = S_IDLE;
        else           state_d = S_BREAK;
      end
      default: state_d = S_IDLE;
    endcase
    brk_det_d = (state_d == S_BREAK);
  end

  // FIFO bookkeeping; a push into an empty FIFO bypasses memory to the head register.
  always_comb begin
    pop_s     = out_valid_q && out_ready;
    full_s    = (count_q == DepthC);
    wr_en_s   = push_q && (!full_s || pop_s);
    ovf_err_d = push_q && full_s && !pop_s;
    if (wr_en_s) wr_ptr_d = wr_ptr_q + PtrW'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (pop_s)   rd_ptr_d = rd_ptr_q + PtrW'(1);
    else         rd_ptr_d = rd_ptr_q;
    if (wr_en_s && !pop_s)      count_d = count_q + 7'd1;
    else if (!wr_en_s && pop_s) count_d = count_q - 7'd1;
    else                        count_d = count_q;
    out_valid_d = (count_d != 7'd0);
    if (count_d == 7'd0)                               out_data_d = out_data_q;
    else if ((count_q - {6'd0, pop_s}) == 7'd0)        out_data_d = shift_q;
    else                                               out_data_d = mem_q[rd_ptr_d];
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_bad_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      push_q      <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      brk_det_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 7'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      par_bit_q   <= par_bit_d;
      push_q      <= push_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      ovf_err_q   <= ovf_err_d;
      brk_det_q   <= brk_det_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Byte storage; contents need no reset because pointers and count define validity.
  always_ff @(posedge Clk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= shift_q;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign frm_err   = frm_err_q;
  assign ovf_err   = ovf_err_q;
  assign brk_det   = brk_det_q;
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued when a frame is sent, checked on pop.
module tb_uart_rx_fifo;
  localparam int B     = 4;
  localparam int DEPTH = 8;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       RX;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] count;
  logic       par_err, frm_err, ovf_err, brk_det;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0;
  int exp_par = 0, exp_frm = 0, exp_ovf = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.BaudRate(B), .FifoDepth(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .RX(RX), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .par_err(par_err), .frm_err(frm_err),
    .ovf_err(ovf_err), .brk_det(brk_det)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshake and pulse monitor on the falling edge, where inputs and outputs are stable.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (par_err) par_cnt++;
      if (frm_err) frm_cnt++;
      if (ovf_err) ovf_cnt++;
      if (out_valid && out_ready) begin
        logic [31:0] e;
        e = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD;
        check_val("rx_byte", {24'd0, out_data}, e);
      end
    end
  end

  task automatic send_bit(input logic v);
    RX = v;
    repeat (2 * B) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(good_par ? ~(^b) : (^b));
    if (!good_par) exp_par++;
`endif
    if (good_par) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovf++;
    end
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic check_errs(input string tag);
    check_val({tag, "_par"}, 32'(par_cnt), 32'(exp_par));
    check_val({tag, "_frm"}, 32'(frm_cnt), 32'(exp_frm));
    check_val({tag, "_ovf"}, 32'(ovf_cnt), 32'(exp_ovf));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge Clk);
    repeat (4) @(posedge Clk);
    #1;
    check_val({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_count0"}, 32'(count), 32'd0);
  endtask

  initial begin
    Rst = 1'b1; RX = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_brk", 32'(brk_det), 32'd0);
    check_val("rst_errs", 32'({par_err, frm_err, ovf_err}), 32'd0);
    Rst = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    // Single frame held in the FIFO
    send_frame(8'h55, 1'b1);
    check_val("f55_valid", 32'(out_valid), 32'd1);
    check_val("f55_count", 32'(count), 32'd1);
    check_val("f55_data", 32'(out_data), 32'h55);
    check_errs("f55");
    out_ready = 1'b1;
    drain("f55");

`ifdef UART_RX_PARITY_EN
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0);
    check_val("badpar_count", 32'(count), 32'd0);
    check_errs("badpar");
`endif

    // Fill past capacity, then drain in order
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b1);
    check_val("full_count", 32'(count), 32'(DEPTH));
    check_val("full_head", 32'(out_data), 32'h01);
    check_errs("full");
    out_ready = 1'b1;
    drain("full");

    // Line break
    RX = 1'b0;
    repeat (30 * 2 * B) @(posedge Clk);
    #1;
    exp_frm++;
`ifdef UART_RX_PARITY_EN
    exp_par++;
`endif
    check_val("brk_high", 32'(brk_det), 32'd1);
    check_errs("brk");
    RX = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    check_val("brk_low", 32'(brk_det), 32'd0);
    check_val("brk_count", 32'(count), 32'd0);

    // Short glitch must be rejected, then a normal frame still decodes
    RX = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    RX = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    check_val("glitch_count", 32'(count), 32'd0);
    check_errs("glitch");
    send_frame(8'h5A, 1'b1);
    drain("glitch");

    // Reset mid-frame loses the partial frame and the FIFO contents
    out_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    Rst = 1'b1; RX = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    exp_q.delete();
    check_val("mrst_count", 32'(count), 32'd0);
    check_val("mrst_valid", 32'(out_valid), 32'd0);
    repeat (4 * B) @(posedge Clk);
    #1;
    send_frame(8'hC3, 1'b1);
    check_val("c3_count", 32'(count), 32'd1);
    check_val("c3_data", 32'(out_data), 32'hC3);
    out_ready = 1'b1;
    drain("c3");

    // Streaming random bytes with the consumer always ready
    for (int k = 0; k < 4; k++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    drain("rand");
    check_errs("final");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter BaudRate, default 4, meaning Clk cycles per half bit period (full bit = 2*BaudRate cycles).
REQ-002 SHALL have parameter FifoDepth, default 8, meaning byte FIFO entries (power of two, 2..64).
REQ-003 SHALL have port Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RX  input  1  asynchronous UART receive line, idle high.
REQ-006 SHALL have port out_data  output  8  byte at FIFO head.
REQ-007 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_data when high with out_valid.
REQ-009 SHALL have port count  output  7  current FIFO occupancy.
REQ-010 SHALL have ports par_err, frm_err, ovf_err  output  1 each  one-cycle error pulses.
REQ-011 SHALL have port brk_det  output  1  line-break level indicator.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-014 IDLE: synchronized RX low -> START; bit counter cleared.
REQ-015 START: sample at BaudRate cycles (mid start bit); high -> IDLE, no error (glitch reject); low -> DATA.
REQ-016 DATA: sample every 2*BaudRate cycles, 8 samples, LSB first into shift register, then -> PARITY (or STOP without parity).
REQ-017 PARITY: one sample; frame valid if total ones in 8 data bits plus parity bit is odd; mismatch -> par_err pulse, frame discarded, still proceed to STOP for resync.
REQ-018 STOP: one sample; high and no parity error -> push byte; low -> frm_err pulse, then BREAK if every sampled bit of the frame was 0, else IDLE.
REQ-019 BREAK: brk_det high; stay until synchronized RX high, then brk_det low and -> IDLE; no byte pushed.
REQ-020 Push occurs the cycle after the stop-bit sample; out_valid rises the following cycle.
REQ-021 Pop when out_valid && out_ready; out_data then shows next entry the following cycle.
REQ-022 Push while count == FifoDepth and no simultaneous pop -> byte dropped, ovf_err pulse, FIFO unchanged.
REQ-023 Simultaneous push and pop when full -> both performed, count unchanged, no ovf_err.
REQ-024 Simultaneous push and pop when empty -> push only (out_valid low that cycle), count becomes 1.
REQ-025 FIFO pointers SHALL wrap modulo FifoDepth; count SHALL never exceed FifoDepth.

Reset
REQ-026 Rst high SHALL force FSM to IDLE, synchronizer flops to 1, pointers and count to 0, out_valid 0, out_data 0, all error outputs and brk_det 0.
REQ-027 Rst mid-frame SHALL abandon the partial frame with no push and no error pulse; FIFO contents lost.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: frame = start, 8 data, odd parity, stop (11 bits); PARITY state and par_err active.
REQ-029 Macro UART_RX_PARITY_EN undefined: frame = start, 8 data, stop (10 bits); PARITY state absent, par_err tied 0.

Verification
REQ-030 Parity on, BaudRate=4: frame 0x55, parity 1, stop 1, out_ready=0 -> out_data 0x55, out_valid 1, count 1, no error pulses.
REQ-031 Parity on: frame 0xA5 with parity bit 0 -> single par_err pulse, count stays 0.
REQ-032 Nine valid frames 0x01..0x09, out_ready=0, FifoDepth=8 -> count 8, ovf_err on ninth; then out_ready=1 -> 0x01..0x08 in order, count 0.
REQ-033 RX low for 30 bit periods, then high -> one frm_err pulse, brk_det high until RX high, no push.
REQ-034 RX low pulse of 2 cycles in IDLE -> no frame, no error, FSM back to IDLE.
REQ-035 Rst for 1 cycle during DATA of frame 0x3C, then full frame 0xC3 -> count 0 after Rst, then only 0xC3 received; parity off: 10-bit frame 0x3C received correctly.
